// File: rtl/thermal_reader_pkg.sv
// -----------------------------------------------------------------------------
// thermal_reader_pkg
// Shared definitions for the thermal sensor frame reader:
//   - state_e                : sequencer state enumeration
//   - DEFAULT_DEVICE_ADDRESS : 7-bit I2C address of the thermal sensor
//   - REG_RAM / REG_STATUS   : sensor register addresses (pixel RAM, status)
//   - DEFAULT_WORD_COUNT     : 768 pixels + 64 auxiliary words
//   - is_ack_wait()          : states in which a byte is on the bus and the
//                              sequencer is waiting for ack or nack
// -----------------------------------------------------------------------------
package thermal_reader_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WR_DEV    = 4'd1,
    WR_REG_HI = 4'd2,
    WR_REG_LO = 4'd3,
    GAP       = 4'd4,
    RD_DEV    = 4'd5,
    RD_HI     = 4'd6,
    RD_LO     = 4'd7,
    FINISH    = 4'd8
  } state_e;

  localparam logic [6:0]  DEFAULT_DEVICE_ADDRESS = 7'h33;
  localparam logic [15:0] REG_RAM                = 16'h0400;
  localparam logic [15:0] REG_STATUS             = 16'h8000;
  localparam int          DEFAULT_WORD_COUNT     = 832;

  // True in every state where a byte is in flight on the bus.
  function automatic logic is_ack_wait(input state_e s);
    logic result;
    case (s)
      WR_DEV, WR_REG_HI, WR_REG_LO, RD_DEV, RD_HI, RD_LO: result = 1'b1;
      default:                                           result = 1'b0;
    endcase
    return result;
  endfunction

  // True when the given start register is the status register rather than RAM.
  function automatic logic is_status_register(input logic [15:0] reg_address);
    return (reg_address == REG_STATUS);
  endfunction

endpackage

// File: rtl/gap_timer.sv
// -----------------------------------------------------------------------------
// gap_timer
// Loadable down-counter. Loading N makes 'expired' assert during the N-th
// cycle after the load edge, so a state entered together with the load lasts
// exactly N cycles when it leaves on 'expired'. The counter parks at zero.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   load        : load load_value on the next edge
//   load_value  : cycle count to time (must be >= 1)
//   expired     : high in the final counted cycle (decoded from the register)
// -----------------------------------------------------------------------------
module gap_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Next count: reload, or count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != {WIDTH{1'b0}}) begin
      count_d = count_q - WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  // Decoded from the register only, so callers may feed 'load' from logic
  // that depends on 'expired' without forming a loop.
  assign expired = (count_q == WIDTH'(1));

endmodule

// File: rtl/thermal_frame_reader.sv
// -----------------------------------------------------------------------------
// thermal_frame_reader
// Sequencer in front of i2c_controller. Writes the 16-bit start register to
// the thermal sensor, waits a stop gap, then reads WORD_COUNT big-endian
// 16-bit words in one read transfer and strobes each assembled word out.
//
// Optional watchdog: define THERMAL_FRAME_READER_WATCHDOG_EN to abort (as for
// nack) when no ack arrives within TIMEOUT_CYCLES in a byte-waiting state.
//
// Ports:
//   clk, reset            : controller (slow) clock, sync active-high reset
//   start                 : pulse, begins a burst when idle
//   busy / done / error   : burst status; done and error are 1-cycle pulses
//   word_data/valid/index : assembled word stream
//   i2c_address, i2c_read_write, i2c_transmit_data, i2c_enable_transfer
//                         : controller command outputs
//   i2c_ack, i2c_nack, i2c_received_data
//                         : controller responses
// -----------------------------------------------------------------------------
module thermal_frame_reader
  import thermal_reader_pkg::*;
#(
  parameter logic [6:0]  DEVICE_ADDRESS  = DEFAULT_DEVICE_ADDRESS,
  parameter logic [15:0] START_REGISTER  = REG_RAM,
  parameter int          WORD_COUNT      = DEFAULT_WORD_COUNT,
  parameter int          INDEX_WIDTH     = 10,
  parameter int          STOP_GAP_CYCLES = 4,
  parameter int          TIMEOUT_CYCLES  = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [15:0]            word_data,
  output logic                   word_valid,
  output logic [INDEX_WIDTH-1:0] word_index,
  output logic [6:0]             i2c_address,
  output logic                   i2c_read_write,
  output logic [7:0]             i2c_transmit_data,
  output logic                   i2c_enable_transfer,
  input  logic                   i2c_ack,
  input  logic                   i2c_nack,
  input  logic [7:0]             i2c_received_data
);

  // One timer width serves both the gap timer and the watchdog instance.
  localparam int MAX_WAIT    = (TIMEOUT_CYCLES > STOP_GAP_CYCLES) ? TIMEOUT_CYCLES
                                                                   : STOP_GAP_CYCLES;
  localparam int TIMER_WIDTH = $clog2(MAX_WAIT + 1);
  localparam logic [TIMER_WIDTH-1:0] GAP_LOAD   = TIMER_WIDTH'(STOP_GAP_CYCLES);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(WORD_COUNT - 1);

  state_e                 state_d,         state_q;
  logic                   busy_d,          busy_q;
  logic                   done_d,          done_q;
  logic                   error_d,         error_q;
  logic [15:0]            word_data_d,     word_data_q;
  logic                   word_valid_d,    word_valid_q;
  logic [INDEX_WIDTH-1:0] word_index_d,    word_index_q;
  logic [6:0]             address_d,       address_q;
  logic                   read_write_d,    read_write_q;
  logic [7:0]             transmit_data_d, transmit_data_q;
  logic                   enable_d,        enable_q;
  logic [7:0]             hi_byte_d,       hi_byte_q;
  logic [INDEX_WIDTH-1:0] count_d,         count_q;
  // Set while FINISH is draining the stop gap after an abort, so no done.
  logic                   abort_d,         abort_q;

  logic gap_load_s;
  logic gap_expired_s;
  logic timeout_s;
  logic abort_s;

  gap_timer #(
    .WIDTH (TIMER_WIDTH)
  ) u_gap_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (gap_load_s),
    .load_value (GAP_LOAD),
    .expired    (gap_expired_s)
  );

`ifdef THERMAL_FRAME_READER_WATCHDOG_EN
  logic wd_load_s;

  // Restart the watchdog on every ack and every state change.
  assign wd_load_s = i2c_ack | (state_d != state_q);

  gap_timer #(
    .WIDTH (TIMER_WIDTH)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .load       (wd_load_s),
    .load_value (TIMER_WIDTH'(TIMEOUT_CYCLES)),
    .expired    (timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // nack beats a simultaneous ack; an ack in the timeout cycle still counts.
  assign abort_s = is_ack_wait(state_q) && (i2c_nack || (timeout_s && !i2c_ack));

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d         = state_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    error_d         = 1'b0;
    word_data_d     = word_data_q;
    word_valid_d    = 1'b0;
    word_index_d    = word_index_q;
    address_d       = DEVICE_ADDRESS;
    read_write_d    = read_write_q;
    transmit_data_d = transmit_data_q;
    enable_d        = enable_q;
    hi_byte_d       = hi_byte_q;
    count_d         = count_q;
    abort_d         = abort_q;
    gap_load_s      = 1'b0;

    if (abort_s) begin
      enable_d   = 1'b0;
      error_d    = 1'b1;
      abort_d    = 1'b1;
      gap_load_s = 1'b1;
      state_d    = FINISH;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_d          = 1'b1;
            read_write_d    = 1'b0;
            transmit_data_d = START_REGISTER[15:8];
            enable_d        = 1'b1;
            count_d         = {INDEX_WIDTH{1'b0}};
            abort_d         = 1'b0;
            state_d         = WR_DEV;
          end else begin
            state_d = IDLE;
          end
        end
        WR_DEV: begin
          if (i2c_ack) begin
            state_d = WR_REG_HI;
          end else begin
            state_d = WR_DEV;
          end
        end
        WR_REG_HI: begin
          if (i2c_ack) begin
            transmit_data_d = START_REGISTER[7:0];
            state_d         = WR_REG_LO;
          end else begin
            state_d = WR_REG_HI;
          end
        end
        WR_REG_LO: begin
          if (i2c_ack) begin
            enable_d   = 1'b0;
            gap_load_s = 1'b1;
            state_d    = GAP;
          end else begin
            state_d = WR_REG_LO;
          end
        end
        GAP: begin
          if (gap_expired_s) begin
            read_write_d = 1'b1;
            enable_d     = 1'b1;
            state_d      = RD_DEV;
          end else begin
            state_d = GAP;
          end
        end
        RD_DEV: begin
          if (i2c_ack) begin
            state_d = RD_HI;
          end else begin
            state_d = RD_DEV;
          end
        end
        RD_HI: begin
          if (i2c_ack) begin
            hi_byte_d = i2c_received_data;
            state_d   = RD_LO;
          end else begin
            state_d = RD_HI;
          end
        end
        RD_LO: begin
          if (i2c_ack) begin
            word_data_d  = {hi_byte_q, i2c_received_data};
            word_valid_d = 1'b1;
            word_index_d = count_q;
            if (count_q == LAST_INDEX) begin
              // Dropping enable now lets the controller nack the last byte
              // and issue stop.
              enable_d   = 1'b0;
              gap_load_s = 1'b1;
              state_d    = FINISH;
            end else begin
              count_d = count_q + INDEX_WIDTH'(1);
              state_d = RD_HI;
            end
          end else begin
            state_d = RD_LO;
          end
        end
        FINISH: begin
          if (gap_expired_s) begin
            busy_d  = 1'b0;
            done_d  = ~abort_q;
            abort_d = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = FINISH;
          end
        end
        default: begin
          enable_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      endcase
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      word_data_q     <= 16'h0000;
      word_valid_q    <= 1'b0;
      word_index_q    <= {INDEX_WIDTH{1'b0}};
      address_q       <= DEVICE_ADDRESS;
      read_write_q    <= 1'b0;
      transmit_data_q <= 8'h00;
      enable_q        <= 1'b0;
      hi_byte_q       <= 8'h00;
      count_q         <= {INDEX_WIDTH{1'b0}};
      abort_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      error_q         <= error_d;
      word_data_q     <= word_data_d;
      word_valid_q    <= word_valid_d;
      word_index_q    <= word_index_d;
      address_q       <= address_d;
      read_write_q    <= read_write_d;
      transmit_data_q <= transmit_data_d;
      enable_q        <= enable_d;
      hi_byte_q       <= hi_byte_d;
      count_q         <= count_d;
      abort_q         <= abort_d;
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign error               = error_q;
  assign word_data           = word_data_q;
  assign word_valid          = word_valid_q;
  assign word_index          = word_index_q;
  assign i2c_address         = address_q;
  assign i2c_read_write      = read_write_q;
  assign i2c_transmit_data   = transmit_data_q;
  assign i2c_enable_transfer = enable_q;

endmodule

// File: tb/tb_thermal_frame_reader.sv
// -----------------------------------------------------------------------------
// tb_thermal_frame_reader
// Directed sequence with random data bytes and random ack latencies. The
// bench plays the i2c_controller, predicts the word stream from the bytes it
// returns (word i = {byte 2i, byte 2i+1}, index i) and checks bus commands,
// gap lengths, status pulses, nack/reset behaviour and the watchdog.
// -----------------------------------------------------------------------------
module tb_thermal_frame_reader;

  localparam int         WC  = 4;
  localparam int         GAP = 4;
  localparam logic [6:0] DEV = 7'h33;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] word_data;
  logic        word_valid;
  logic [9:0]  word_index;
  logic [6:0]  i2c_address;
  logic        i2c_read_write;
  logic [7:0]  i2c_transmit_data;
  logic        i2c_enable_transfer;
  logic        i2c_ack;
  logic        i2c_nack;
  logic [7:0]  i2c_received_data;

  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;
  int error_cnt  = 0;

  logic [15:0] got_data_q[$];
  int          got_idx_q[$];
  logic [7:0]  data_bytes[2*WC];

  thermal_frame_reader #(
    .WORD_COUNT  (WC),
    .INDEX_WIDTH (10)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .busy                (busy),
    .done                (done),
    .error               (error),
    .word_data           (word_data),
    .word_valid          (word_valid),
    .word_index          (word_index),
    .i2c_address         (i2c_address),
    .i2c_read_write      (i2c_read_write),
    .i2c_transmit_data   (i2c_transmit_data),
    .i2c_enable_transfer (i2c_enable_transfer),
    .i2c_ack             (i2c_ack),
    .i2c_nack            (i2c_nack),
    .i2c_received_data   (i2c_received_data)
  );

  always #5 clk = ~clk;

  // Collect word strobes and status pulses away from the active edge.
  always @(negedge clk) begin
    if (word_valid) begin
      got_data_q.push_back(word_data);
      got_idx_q.push_back(int'(word_index));
    end
    if (done)  done_cnt  <= done_cnt + 1;
    if (error) error_cnt <= error_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Controller acknowledges one byte after a random latency.
  task automatic ack_byte(input logic [7:0] b);
    int d;
    d = int'($urandom_range(0, 2));
    repeat (d) cycle();
    i2c_ack           = 1'b1;
    i2c_received_data = b;
    cycle();
    i2c_ack           = 1'b0;
    i2c_received_data = 8'($urandom);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 2 * WC; i++) data_bytes[i] = 8'($urandom);
  endtask

  // Start through the read address ack; ends with the sequencer in RD_HI.
  task automatic begin_burst();
    int gap;
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_en",   32'(i2c_enable_transfer), 32'd1);
    chk("start_rw",   32'(i2c_read_write), 32'd0);
    chk("start_tx",   32'(i2c_transmit_data), 32'h04);
    ack_byte(8'($urandom));
    chk("wr_hi_tx", 32'(i2c_transmit_data), 32'h04);
    ack_byte(8'($urandom));
    chk("wr_lo_tx", 32'(i2c_transmit_data), 32'h00);
    chk("wr_lo_rw", 32'(i2c_read_write), 32'd0);
    ack_byte(8'($urandom));
    gap = 0;
    while (!i2c_enable_transfer && gap < 20) begin
      gap++;
      cycle();
    end
    chk("gap_len", 32'(gap), 32'(GAP));
    chk("rd_rw",   32'(i2c_read_write), 32'd1);
    chk("rd_en",   32'(i2c_enable_transfer), 32'd1);
    ack_byte(8'($urandom));
  endtask

  // Full burst using data_bytes; nack_word >= 0 nacks (with a coincident ack)
  // the low byte of that word.
  task automatic run_burst(input int nack_word, input bit extra_start);
    int fin;
    int n_exp;
    int d0;
    int e0;
    got_data_q.delete();
    got_idx_q.delete();
    d0 = done_cnt;
    e0 = error_cnt;
    begin_burst();
    for (int w = 0; w < WC; w++) begin
      ack_byte(data_bytes[2*w]);
      if (extra_start && w == 1) begin
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("busy_start_rw", 32'(i2c_read_write), 32'd1);
        chk("busy_start_en", 32'(i2c_enable_transfer), 32'd1);
      end
      if (w == nack_word) begin
        i2c_ack           = 1'b1;
        i2c_nack          = 1'b1;
        i2c_received_data = data_bytes[2*w+1];
        cycle();
        i2c_ack  = 1'b0;
        i2c_nack = 1'b0;
        chk("nack_err", 32'(error), 32'd1);
        chk("nack_en",  32'(i2c_enable_transfer), 32'd0);
        break;
      end
      ack_byte(data_bytes[2*w+1]);
    end
    fin = 0;
    while (busy && fin < 20) begin
      fin++;
      cycle();
    end
    chk("fin_len",  32'(fin), 32'(GAP));
    chk("fin_done", 32'(done), (nack_word < 0) ? 32'd1 : 32'd0);
    chk("fin_en",   32'(i2c_enable_transfer), 32'd0);
    cycle();
    n_exp = (nack_word < 0) ? WC : nack_word;
    chk("word_count", 32'(got_data_q.size()), 32'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      if (i < got_data_q.size()) begin
        chk("word_data", 32'(got_data_q[i]), {16'h0000, data_bytes[2*i], data_bytes[2*i+1]});
        chk("word_idx",  32'(got_idx_q[i]), 32'(i));
      end
    end
    chk("done_pulses",  32'(done_cnt - d0),  (nack_word < 0) ? 32'd1 : 32'd0);
    chk("error_pulses", 32'(error_cnt - e0), (nack_word < 0) ? 32'd0 : 32'd1);
  endtask

  initial begin
    int d0;
    int e0;
    int fin;
    int cnt;
    bit en_seen;

    reset             = 1'b1;
    start             = 1'b0;
    i2c_ack           = 1'b0;
    i2c_nack          = 1'b0;
    i2c_received_data = 8'h00;
    repeat (3) cycle();
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_data",  32'(word_data), 32'd0);
    chk("rst_index", 32'(word_index), 32'd0);
    chk("rst_addr",  32'(i2c_address), 32'(DEV));
    chk("rst_rw",    32'(i2c_read_write), 32'd0);
    chk("rst_tx",    32'(i2c_transmit_data), 32'd0);
    chk("rst_en",    32'(i2c_enable_transfer), 32'd0);
    reset = 1'b0;
    cycle();

    // Nominal burst with fixed data.
    data_bytes = '{8'hB3, 8'h12, 8'h00, 8'hFF, 8'h7E, 8'h01, 8'h80, 8'h00};
    run_burst(-1, 1'b0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Random data bursts.
    repeat (2) begin
      fill_random();
      run_burst(-1, 1'b0);
    end

    // Address nack.
    got_data_q.delete();
    got_idx_q.delete();
    d0 = done_cnt;
    e0 = error_cnt;
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (2) cycle();
    i2c_nack = 1'b1;
    cycle();
    i2c_nack = 1'b0;
    chk("anack_err", 32'(error), 32'd1);
    chk("anack_en",  32'(i2c_enable_transfer), 32'd0);
    fin = 0;
    en_seen = 1'b0;
    while (busy && fin < 20) begin
      fin++;
      cycle();
      if (i2c_enable_transfer) en_seen = 1'b1;
    end
    chk("anack_fin", 32'(fin), 32'(GAP));
    repeat (8) begin
      cycle();
      if (i2c_enable_transfer) en_seen = 1'b1;
    end
    chk("anack_en_rise", 32'(en_seen), 32'd0);
    chk("anack_words",   32'(got_data_q.size()), 32'd0);
    chk("anack_errors",  32'(error_cnt - e0), 32'd1);
    chk("anack_dones",   32'(done_cnt - d0), 32'd0);

    // nack after word 1 (coincident with an ack on word 2's low byte).
    fill_random();
    run_burst(2, 1'b0);

    // Reset in RD_HI.
    got_data_q.delete();
    got_idx_q.delete();
    d0 = done_cnt;
    e0 = error_cnt;
    begin_burst();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("mrst_busy",  32'(busy), 32'd0);
    chk("mrst_en",    32'(i2c_enable_transfer), 32'd0);
    chk("mrst_rw",    32'(i2c_read_write), 32'd0);
    chk("mrst_tx",    32'(i2c_transmit_data), 32'd0);
    chk("mrst_data",  32'(word_data), 32'd0);
    chk("mrst_index", 32'(word_index), 32'd0);
    chk("mrst_addr",  32'(i2c_address), 32'(DEV));
    repeat (8) cycle();
    chk("mrst_idle_en", 32'(i2c_enable_transfer), 32'd0);
    chk("mrst_errors",  32'(error_cnt - e0), 32'd0);
    chk("mrst_dones",   32'(done_cnt - d0), 32'd0);
    chk("mrst_words",   32'(got_data_q.size()), 32'd0);

    // Start while busy is ignored; burst runs from index 0.
    fill_random();
    run_burst(-1, 1'b1);

    // Watchdog.
    e0 = error_cnt;
    start = 1'b1;
    cycle();
    start = 1'b0;
    ack_byte(8'($urandom));
`ifdef THERMAL_FRAME_READER_WATCHDOG_EN
    cnt = 0;
    while (!error && cnt < 300) begin
      cnt++;
      cycle();
    end
    chk("wd_cycles", 32'(cnt), 32'd64);
    chk("wd_en",     32'(i2c_enable_transfer), 32'd0);
    fin = 0;
    while (busy && fin < 20) begin
      fin++;
      cycle();
    end
    chk("wd_fin", 32'(fin), 32'(GAP));
    cycle();
    chk("wd_errors", 32'(error_cnt - e0), 32'd1);
`else
    cnt = 0;
    repeat (200) begin
      cnt++;
      cycle();
    end
    chk("nowd_busy",   32'(busy), 32'd1);
    chk("nowd_en",     32'(i2c_enable_transfer), 32'd1);
    chk("nowd_errors", 32'(error_cnt - e0), 32'd0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
